// File: rtl/axonerve_kvs_axis_out_slice.sv
// Registered AXI4-Stream slice with 2-entry skid buffer; 1-cycle latency, full throughput.
// Backpressure: registered s_axis_tready drops only while the skid holds a beat.
module axonerve_kvs_axis_out_slice #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_COUNT_WIDTH      = 32
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            ctrl_clear,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [C_COUNT_WIDTH-1:0]        stat_beats,
    output logic [C_COUNT_WIDTH-1:0]        stat_pkts,
    output logic                            stat_idle
);
    localparam int KW = C_AXIS_TDATA_WIDTH / 8;

    typedef struct packed {
        logic [C_AXIS_TDATA_WIDTH-1:0] dat;
        logic [KW-1:0]                 keep;
        logic                          last;
    } beat_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t                   state_q, state_d;
    beat_t                    main_q, main_d, skid_q, skid_d, in_beat;
    logic                     m_vld_q, m_vld_d;
    logic                     s_rdy_q, s_rdy_d;
    logic                     idle_q, idle_d;
    logic [C_COUNT_WIDTH-1:0] beats_q, beats_d, pkts_q, pkts_d;
    logic                     in_hs, out_hs;
    logic [C_COUNT_WIDTH-1:0] beat_inc, pkt_inc;

    assign in_beat = '{dat: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        in_hs    = s_axis_tvalid & s_rdy_q;
        out_hs   = m_vld_q & m_axis_tready;
        beat_inc = '0;
        pkt_inc  = '0;

        case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    main_d  = in_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_hs && out_hs) begin
                    main_d = in_beat;
                end else if (in_hs) begin
                    skid_d  = in_beat;
                    state_d = ST_FULL;
                end else if (out_hs) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // tready is low here, so only the drain side can move
                if (out_hs) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        m_vld_d = (state_d != ST_EMPTY);
        s_rdy_d = (state_d != ST_FULL);
        idle_d  = (state_d == ST_EMPTY);

        beat_inc[0] = out_hs;
        pkt_inc[0]  = out_hs & main_q.last;
        // A clear still counts the handshake that happens in the same cycle
        beats_d = ctrl_clear ? beat_inc : beats_q + beat_inc;
        pkts_d  = ctrl_clear ? pkt_inc  : pkts_q + pkt_inc;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_EMPTY;
            m_vld_q <= 1'b0;
            s_rdy_q <= 1'b0;
            idle_q  <= 1'b1;
            beats_q <= '0;
            pkts_q  <= '0;
        end else begin
            state_q <= state_d;
            m_vld_q <= m_vld_d;
            s_rdy_q <= s_rdy_d;
            idle_q  <= idle_d;
            beats_q <= beats_d;
            pkts_q  <= pkts_d;
        end
    end

    // Payload registers carry no reset; they are qualified by m_vld_q / state_q
    always_ff @(posedge aclk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign m_axis_tvalid = m_vld_q;
    assign s_axis_tready = s_rdy_q;
    assign m_axis_tdata  = main_q.dat;
    assign m_axis_tkeep  = main_q.keep;
    assign m_axis_tlast  = main_q.last;
    assign stat_beats    = beats_q;
    assign stat_pkts     = pkts_q;
    assign stat_idle     = idle_q;

endmodule

// File: tb/tb_axonerve_kvs_axis_out_slice.sv
// Bench for the output slice: queue-based reference model checked every cycle,
// directed scenarios plus a randomized stream, and a narrow-counter instance for wrap.
module tb_axonerve_kvs_axis_out_slice;
    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ctrl_clear;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          m_axis_tvalid, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [31:0]   stat_beats, stat_pkts;
    logic          stat_idle;

    logic          d2_s_vld, d2_s_rdy, d2_s_last, d2_m_vld, d2_m_rdy, d2_m_last, d2_idle;
    logic [7:0]    d2_s_dat, d2_m_dat;
    logic [0:0]    d2_s_keep, d2_m_keep;
    logic [3:0]    d2_beats, d2_pkts;

    always #5 aclk = ~aclk;

    axonerve_kvs_axis_out_slice #(.C_AXIS_TDATA_WIDTH(DW), .C_COUNT_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset), .ctrl_clear(ctrl_clear),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .stat_beats(stat_beats), .stat_pkts(stat_pkts), .stat_idle(stat_idle)
    );

    axonerve_kvs_axis_out_slice #(.C_AXIS_TDATA_WIDTH(8), .C_COUNT_WIDTH(4)) dut_w4 (
        .aclk(aclk), .areset(areset), .ctrl_clear(1'b0),
        .s_axis_tvalid(d2_s_vld), .s_axis_tready(d2_s_rdy),
        .s_axis_tdata(d2_s_dat), .s_axis_tkeep(d2_s_keep), .s_axis_tlast(d2_s_last),
        .m_axis_tvalid(d2_m_vld), .m_axis_tready(d2_m_rdy),
        .m_axis_tdata(d2_m_dat), .m_axis_tkeep(d2_m_keep), .m_axis_tlast(d2_m_last),
        .stat_beats(d2_beats), .stat_pkts(d2_pkts), .stat_idle(d2_idle)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Reference model: the slice is a FIFO of depth 2 with one cycle of latency.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } mbeat_t;

    mbeat_t      q[$];
    logic [31:0] mb = '0;
    logic [31:0] mp = '0;
    bit          rst_last = 1'b1;

    always @(negedge aclk) begin
        bit ihs, ohs, lst;
        chk("m_tvalid", m_axis_tvalid, q.size() > 0);
        chk("s_tready", s_axis_tready, !rst_last && q.size() < 2);
        chk("stat_idle", stat_idle, q.size() == 0);
        chk("stat_beats", stat_beats, mb);
        chk("stat_pkts", stat_pkts, mp);
        if (q.size() > 0) begin
            chk("m_tdata", m_axis_tdata, q[0].d);
            chk("m_tkeep", m_axis_tkeep, q[0].k);
            chk("m_tlast", m_axis_tlast, q[0].l);
        end
        if (areset) begin
            q.delete();
            mb = '0;
            mp = '0;
            rst_last = 1'b1;
        end else begin
            ihs = s_axis_tvalid && !rst_last && q.size() < 2;
            ohs = q.size() > 0 && m_axis_tready;
            lst = ohs && q[0].l;
            mb = ctrl_clear ? 32'(ohs) : mb + 32'(ohs);
            mp = ctrl_clear ? 32'(lst) : mp + 32'(lst);
            if (ohs) void'(q.pop_front());
            if (ihs) q.push_back('{s_axis_tdata, s_axis_tkeep, s_axis_tlast});
            rst_last = 1'b0;
        end
    end

    task automatic offer(input int idx, input int lastmod, input bit rnd);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rnd ? {$urandom, $urandom} : 64'(idx);
        s_axis_tkeep  = rnd ? 8'($urandom) : 8'hFF;
        s_axis_tlast  = (idx % lastmod) == (lastmod - 1);
    endtask

    // Streams n beats; pv/pr are valid/ready percentages. Also confirms that
    // changing the inputs never moves the handshake outputs before the next edge.
    task automatic send(input int n, input int pv, input int pr, input int lastmod, input bit rnd);
        int   idx = 0;
        int   cyc = 0;
        logic hs, o_v, o_r;
        while (idx < n) begin
            @(negedge aclk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            o_v = m_axis_tvalid;
            o_r = s_axis_tready;
            if (hs) idx++;
            if (hs || !s_axis_tvalid) begin
                if (idx < n && $urandom_range(99) < pv) offer(idx, lastmod, rnd);
                else s_axis_tvalid = 1'b0;
            end
            m_axis_tready = $urandom_range(99) < pr;
            #1;
            chk("comb_m_tvalid", m_axis_tvalid, o_v);
            chk("comb_s_tready", s_axis_tready, o_r);
            cyc++;
            if (cyc > 80000) begin
                timeout("send");
                s_axis_tvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_accept(input string nm);
        int cyc = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge aclk);
            done = s_axis_tvalid && s_axis_tready;
            tick();
            cyc++;
            if (!done && cyc > 50) begin
                timeout(nm);
                done = 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        int cnt;
        int cyc;
        areset = 1'b1;
        ctrl_clear = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        d2_s_vld = 1'b0; d2_s_dat = '0; d2_s_keep = 1'b1; d2_s_last = 1'b1; d2_m_rdy = 1'b1;
        repeat (3) tick();
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_idle", stat_idle, 1'b1);
        areset = 1'b0;
        tick();
        chk("tready_after_rst", s_axis_tready, 1'b1);

        // Back-to-back 8-beat packet with downstream always ready
        send(8, 100, 100, 8, 1'b0);
        drain();
        chk("t1_beats", stat_beats, 32'd8);
        chk("t1_pkts", stat_pkts, 32'd1);
        chk("t1_idle", stat_idle, 1'b1);

        // 17 single-beat packets into the 4-bit counter instance
        cnt = 0;
        cyc = 0;
        d2_s_vld = 1'b1;
        while (cnt < 17 && cyc < 100) begin
            @(negedge aclk);
            if (d2_s_vld && d2_s_rdy) cnt++;
            tick();
            d2_s_dat = 8'(cnt);
            if (cnt == 17) d2_s_vld = 1'b0;
            cyc++;
        end
        d2_s_vld = 1'b0;
        if (cnt < 17) timeout("wrap_send");
        repeat (3) tick();
        chk("wrap_beats", d2_beats, 4'd1);
        chk("wrap_pkts", d2_pkts, 4'd1);

        // Stall: A and B absorbed, C held upstream
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tkeep = 8'hFF; s_axis_tlast = 1'b0;
        s_axis_tdata = 64'hA;
        tick();
        s_axis_tdata = 64'hB;
        tick();
        s_axis_tdata = 64'hC;
        repeat (3) begin
            chk("stall_tready", s_axis_tready, 1'b0);
            chk("stall_tdata", m_axis_tdata, 64'hA);
            tick();
        end
        m_axis_tready = 1'b1;
        wait_accept("stall_c");
        drain();
        chk("t2_beats", stat_beats, 32'd11);
        chk("t2_pkts", stat_pkts, 32'd1);

        // Clear coinciding with a tlast handshake
        send(4, 100, 100, 1, 1'b0);
        drain();
        m_axis_tready = 1'b0;
        offer(5, 1, 1'b0);
        wait_accept("clr_beat");
        m_axis_tready = 1'b1;
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
        chk("clr_beats", stat_beats, 32'd1);
        chk("clr_pkts", stat_pkts, 32'd1);

        // Randomized stream
        drain();
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
        send(10000, 50, 50, 16, 1'b1);
        drain();
        chk("rnd_beats", stat_beats, 32'd10000);
        chk("rnd_pkts", stat_pkts, 32'd625);

        // Reset while FULL
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tkeep = 8'hFF;
        s_axis_tdata = 64'h111;
        tick();
        s_axis_tdata = 64'h222;
        tick();
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_idle", stat_idle, 1'b1);
        chk("mid_rst_beats", stat_beats, 32'd0);
        chk("mid_rst_tready", s_axis_tready, 1'b0);
        tick();
        chk("post_rst_tready", s_axis_tready, 1'b1);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 64'h5EED;
        tick();
        s_axis_tvalid = 1'b0;
        chk("post_rst_tvalid", m_axis_tvalid, 1'b1);
        chk("post_rst_tdata", m_axis_tdata, 64'h5EED);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
